// File: rtl/fs_serial_pkg.sv
// fs_serial_pkg: shared types and elaboration-time helpers for the
// digit-serial full subtractor (fs_serial).
package fs_serial_pkg;

    // Controller states; 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fs_state_e;

    // Legal configuration: at least 2 bits wide, and the digit size must
    // split the word into a whole number of steps.
    function automatic bit fs_params_ok(input int width, input int digit);
        return (width >= 2) && (digit >= 1) && (digit <= width) &&
               ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/fs_bit.sv
// fs_bit: single-bit full subtractor cell, d = a - b - bin, purely combinational.
module fs_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference is odd parity; borrow when b (or the incoming borrow)
    // outweighs a at this bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/fs_serial.sv
// fs_serial: multi-cycle subtractor, diff = a - b - b_in (mod 2^WIDTH),
// DIGIT bits per clock LSB first, with a registered borrow between digits.
// Optional macro FS_SERIAL_OVF_EN adds a signed-overflow output (ovf).
module fs_serial
    import fs_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef FS_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (!fs_params_ok(WIDTH, DIGIT)) begin : g_param_err
        $error("fs_serial: WIDTH must be >= 2 and an exact multiple of DIGIT");
    end

    fs_state_e        state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             bor_q;
    logic [WIDTH-1:0] diff_q;
    logic             in_ready_q;
    logic             out_valid_q;

    // Per-cycle borrow chain across DIGIT bit cells; chain[0] is the
    // borrow carried over from the previous digit.
    logic [DIGIT:0]       chain;
    logic [DIGIT-1:0]     d_digit;
    logic [WIDTH+DIGIT-1:0] diff_cat;

    assign chain[0] = bor_q;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        fs_bit u_bit (
            .a    (a_sh[i]),
            .b    (b_sh[i]),
            .bin  (chain[i]),
            .d    (d_digit[i]),
            .bout (chain[i+1])
        );
    end

    // New digit enters from the MSB side; after STEPS shifts the first
    // digit has walked down to bit 0.
    assign diff_cat = {d_digit, diff_q};

    // Controller, operand shifters and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            a_sh        <= '0;
            b_sh        <= '0;
            bor_q       <= 1'b0;
            diff_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh       <= a;
                        b_sh       <= b;
                        bor_q      <= b_in;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    diff_q <= diff_cat[WIDTH+DIGIT-1:DIGIT];
                    bor_q  <= chain[DIGIT];
                    if (cnt == LAST) begin
                        cnt         <= '0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    // Result holds here; the slot frees only after the
                    // consumer takes it, never in the same cycle.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = bor_q;

`ifdef FS_SERIAL_OVF_EN
    logic a_msb;
    logic b_msb;

    // Operand sign bits are captured at accept since the shifters lose them.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end
    end

    // Signed overflow: operands of differing sign and the result sign
    // disagrees with the minuend.
    assign ovf = (a_msb ^ b_msb) & (a_msb ^ diff_q[WIDTH-1]);
`endif

endmodule

// File: tb/tb_fs_serial.sv
// tb_fs_serial: scoreboard bench for fs_serial, two instances (DIGIT=1 and
// DIGIT=4), directed + random operands against an arithmetic reference.
module tb_fs_serial;

    localparam int W = 8;
    localparam int NDIR = 8;
    localparam logic [W-1:0] DIR_A [NDIR] = '{8'h5A, 8'h00, 8'h10, 8'hA5, 8'h80, 8'h05, 8'hFF, 8'h00};
    localparam logic [W-1:0] DIR_B [NDIR] = '{8'h3C, 8'h01, 8'h0F, 8'hA5, 8'h01, 8'h03, 8'h00, 8'hFF};
    localparam logic         DIR_C [NDIR] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};

    typedef struct {
        logic [W-1:0] d;
        logic         br;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain (W+1)-bit unsigned subtraction; the top bit is the borrow.
    function automatic exp_t ref_model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        exp_t e;
        logic [W:0] r;
        r     = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
        e.d   = r[W-1:0];
        e.br  = r[W];
        e.ovf = (av[W-1] ^ bv[W-1]) & (av[W-1] ^ r[W-1]);
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int DG = (g == 0) ? 1 : 4;
        localparam int ST = W / DG;

        logic         rst, in_valid, in_ready, b_in, out_valid, out_ready, borrow;
        logic [W-1:0] a, b, diff;
`ifdef FS_SERIAL_OVF_EN
        logic         ovf;
`endif
        exp_t         q[$];

        fs_serial #(.WIDTH(W), .DIGIT(DG)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .b_in      (b_in),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .diff      (diff),
            .borrow    (borrow)
`ifdef FS_SERIAL_OVF_EN
            ,
            .ovf       (ovf)
`endif
        );

        task automatic lchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
            chk($sformatf("lane%0d_%s", g, nm), act, exp);
        endtask

        // Monitor: compare every delivered result against the oldest expectation.
        always @(negedge clk) begin
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL lane%0d_unexpected_out: got diff %0h with no result pending", g, diff);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    lchk("diff", 32'(diff), 32'(e.d));
                    lchk("borrow", 32'(borrow), 32'(e.br));
`ifdef FS_SERIAL_OVF_EN
                    lchk("ovf", 32'(ovf), 32'(e.ovf));
`endif
                end
            end
        end

        // Wait (bounded) until the block shows in_ready; returns after the accept edge.
        task automatic wait_accept();
            int k;
            k = 0;
            @(negedge clk);
            while (!in_ready && k < 50) begin
                @(negedge clk);
                k++;
            end
            lchk("accept_wait", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
        endtask

        // One full transaction; called and returns at posedge+1.
        task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi, input int hold);
            exp_t e;
            int   k;
            bit   busy_ok;
            a = av; b = bv; b_in = bi; in_valid = 1'b1;
            wait_accept();
            e = ref_model(av, bv, bi);
            q.push_back(e);
            // Scramble operand pins: the block must work from its captured copy.
            in_valid = 1'b0; a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
            out_ready = 1'b0;
            k = 0;
            busy_ok = 1'b1;
            while (k < 40) begin
                @(negedge clk);
                k++;
                if (out_valid) break;
                if (in_ready) busy_ok = 1'b0;
            end
            lchk("latency_edges", 32'(k), 32'(ST + 1));
            lchk("in_ready_busy", 32'(busy_ok), 32'd1);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                lchk("hold_valid", 32'(out_valid), 32'd1);
                lchk("hold_diff", 32'(diff), 32'(e.d));
                lchk("hold_borrow", 32'(borrow), 32'(e.br));
`ifdef FS_SERIAL_OVF_EN
                lchk("hold_ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
            @(posedge clk);
            #1;
            // Present a new operand during the handshake cycle: it must not
            // be taken until in_ready comes back.
            out_ready = 1'b1;
            in_valid  = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            in_valid  = 1'b0;
            lchk("ready_after_hs", 32'(in_ready), 32'd1);
            lchk("valid_after_hs", 32'(out_valid), 32'd0);
        endtask

        // Start an operation, then reset it partway through RUN.
        task automatic abort_op(input logic [W-1:0] av, input logic [W-1:0] bv);
            int  n;
            bit  seen;
            a = av; b = bv; b_in = 1'b0; in_valid = 1'b1;
            wait_accept();
            in_valid = 1'b0;
            n = (ST > 3) ? 3 : ST - 1;
            repeat (n) @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            lchk("abort_in_ready", 32'(in_ready), 32'd1);
            lchk("abort_out_valid", 32'(out_valid), 32'd0);
            lchk("abort_diff", 32'(diff), 32'd0);
            lchk("abort_borrow", 32'(borrow), 32'd0);
            out_ready = 1'b1;
            seen = 1'b0;
            repeat (20) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            lchk("abort_no_result", 32'(seen), 32'd0);
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        endtask

        // Stimulus for this lane.
        initial begin
            rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; b_in = 1'b0; out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            lchk("rst_in_ready", 32'(in_ready), 32'd1);
            lchk("rst_out_valid", 32'(out_valid), 32'd0);
            lchk("rst_diff", 32'(diff), 32'd0);
            lchk("rst_borrow", 32'(borrow), 32'd0);
            rst = 1'b0;
            for (int i = 0; i < NDIR; i++) begin
                op(DIR_A[i], DIR_B[i], DIR_C[i], (i == 0) ? 5 : 0);
            end
            abort_op(8'hC3, 8'h42);
            for (int i = 0; i < 25; i++) begin
                op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
            end
            lchk("queue_drained", 32'(q.size()), 32'd0);
            done_cnt++;
        end
    end

    // Wait for both lanes (bounded), then report.
    initial begin
        fork
            wait (done_cnt == 2);
            repeat (30000) @(posedge clk);
        join_any
        disable fork;
        if (done_cnt != 2) begin
            errors++;
            checks++;
            $display("FAIL timeout: lanes finished %0d expected 2", done_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
